// File: rtl/acondicionador_botones_pkg.sv
// Shared definitions for the push-button conditioning stage:
// per-channel FSM encoding and default timing for a 100 MHz clock.
package acondicionador_botones_pkg;

  // Per-channel debounce FSM states.
  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    DEB_RELEASE = 2'd3
  } estado_t;

  // Default timing at 100 MHz.
  localparam int DEB_CYCLES_DEF    = 500000;    // 5 ms debounce
  localparam int HOLD_CYCLES_DEF   = 50000000;  // 0.5 s before first repeat
  localparam int REPEAT_CYCLES_DEF = 10000000;  // 0.1 s repeat period
  localparam int CNT_W_DEF         = 26;

endpackage

// File: rtl/acondicionador_botones_canal_antirrebote.sv
// One button channel: 2-FF synchronizer, debounce FSM, debounce timer and
// hold/repeat timer. pulso is a registered single-cycle pulse issued on an
// accepted press and, when REPEAT_EN is set, on each auto-repeat while held.
// estado exposes the FSM state for observation.
module canal_antirrebote
  import acondicionador_botones_pkg::*;
#(
  parameter int DEB_CYCLES    = DEB_CYCLES_DEF,
  parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF,
  parameter int CNT_W         = CNT_W_DEF,
  parameter bit REPEAT_EN     = 1'b1
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    boton,
  output logic    pulso,
  output estado_t estado
);

  localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LIM    = CNT_W'(HOLD_CYCLES);
  // Reloading here after a repeat makes the next compare hit HOLD_LIM exactly
  // REPEAT_CYCLES later, so the hold timer never exceeds HOLD_LIM or wraps.
  localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD_CYCLES - REPEAT_CYCLES + 1);

  logic [1:0]       sync_q;
  logic             s_in;
  logic [CNT_W-1:0] deb_cnt;
  logic [CNT_W-1:0] hold_cnt;

  assign s_in = sync_q[1];

  // Two-flop synchronizer for the asynchronous raw button.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], boton};
  end

  // Debounce FSM with hold/repeat timing; pulso is registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado   <= IDLE;
      deb_cnt  <= '0;
      hold_cnt <= '0;
      pulso    <= 1'b0;
    end else begin
      pulso <= 1'b0;
      case (estado)
        IDLE: begin
          if (s_in) begin
            estado  <= DEB_PRESS;
            deb_cnt <= ONE;
          end
        end
        DEB_PRESS: begin
          if (!s_in) begin
            estado <= IDLE;
          end else if (deb_cnt == DEB_LAST) begin
            estado   <= PRESSED;
            pulso    <= 1'b1;
            hold_cnt <= ONE;
          end else begin
            deb_cnt <= deb_cnt + ONE;
          end
        end
        PRESSED: begin
          if (!s_in) begin
            estado  <= DEB_RELEASE;
            deb_cnt <= ONE;
          end else if (REPEAT_EN) begin
            if (hold_cnt == HOLD_LIM) begin
              pulso    <= 1'b1;
              hold_cnt <= HOLD_RELOAD;
            end else begin
              hold_cnt <= hold_cnt + ONE;
            end
          end
        end
        DEB_RELEASE: begin
          if (s_in) begin
            // Release was a glitch: back to held, repeat schedule restarts.
            estado   <= PRESSED;
            hold_cnt <= ONE;
          end else if (deb_cnt == DEB_LAST) begin
            estado <= IDLE;
          end else begin
            deb_cnt <= deb_cnt + ONE;
          end
        end
        default: estado <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/acondicionador_botones.sv
// Input conditioning for the DPWM top: debounced single-cycle pulses for the
// up (au), down (dis) and mode-select (sel) buttons. au/dis auto-repeat while
// held; simultaneous au/dis pulses cancel each other. Each output is a
// registered strobe, high for exactly one clock per event.
module acondicionador_botones
  import acondicionador_botones_pkg::*;
#(
  parameter int DEB_CYCLES    = DEB_CYCLES_DEF,
  parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic aumentar,
  input  logic disminuir,
  input  logic seleccion,
  output logic au,
  output logic dis,
  output logic sel
);

  // Reject timing combinations that would break the one-cycle pulse guarantee
  // or overflow the timers.
  if (DEB_CYCLES < 2 || REPEAT_CYCLES < 2 || HOLD_CYCLES < REPEAT_CYCLES ||
      (DEB_CYCLES >> CNT_W) != 0 || (HOLD_CYCLES >> CNT_W) != 0 ||
      (REPEAT_CYCLES >> CNT_W) != 0) begin : g_param_err
    $error("acondicionador_botones: illegal timing parameters");
  end

  logic    pulso_au, pulso_dis, pulso_sel;
  estado_t estado_au, estado_dis, estado_sel;

  canal_antirrebote #(
    .DEB_CYCLES(DEB_CYCLES), .HOLD_CYCLES(HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES), .CNT_W(CNT_W), .REPEAT_EN(1'b1)
  ) u_canal_au (
    .clk(clk), .reset(reset), .boton(aumentar),
    .pulso(pulso_au), .estado(estado_au)
  );

  canal_antirrebote #(
    .DEB_CYCLES(DEB_CYCLES), .HOLD_CYCLES(HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES), .CNT_W(CNT_W), .REPEAT_EN(1'b1)
  ) u_canal_dis (
    .clk(clk), .reset(reset), .boton(disminuir),
    .pulso(pulso_dis), .estado(estado_dis)
  );

  canal_antirrebote #(
    .DEB_CYCLES(DEB_CYCLES), .HOLD_CYCLES(HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES), .CNT_W(CNT_W), .REPEAT_EN(1'b0)
  ) u_canal_sel (
    .clk(clk), .reset(reset), .boton(seleccion),
    .pulso(pulso_sel), .estado(estado_sel)
  );

  // Output registers; coincident up/down pulses cancel so the counters never
  // see contradictory commands in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      au  <= 1'b0;
      dis <= 1'b0;
      sel <= 1'b0;
    end else begin
      au  <= pulso_au & ~pulso_dis;
      dis <= pulso_dis & ~pulso_au;
      sel <= pulso_sel;
    end
  end

endmodule
